// File: rtl/ecc_host_link_pkg.sv
// Shared definitions for the ECC host link: operand width, length modes,
// FSM state encodings and the length decode helper.
package ecc_host_link_pkg;

  localparam int ECC_MAX_BITS = 256;
  localparam int CNT_W        = 9;

  typedef enum logic [1:0] {
    MODE_32  = 2'b00,
    MODE_64  = 2'b01,
    MODE_128 = 2'b10,
    MODE_256 = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_VALID,
    TX_MODE1,
    TX_MODE0,
    TX_DATA
  } tx_state_e;

  typedef enum logic [1:0] {
    NP_IDLE,
    NP_WAIT,
    NP_VALID,
    NP_DATA
  } np_state_e;

  typedef enum logic [1:0] {
    CAP_IDLE,
    CAP_WAIT,
    CAP_SHIFT,
    CAP_FULL
  } cap_state_e;

  // Terminal bit index (N-1) for a length mode.
  function automatic logic [CNT_W-1:0] bits_m1(input mode_e m);
    return CNT_W'((32 << m) - 1);
  endfunction

endpackage

// File: rtl/ecc_serial_capture.sv
// One result channel: arms on start, then captures an MSB-first serial pair
// into an N-bit window beginning on the cycle its valid marker is seen.
module ecc_serial_capture
  import ecc_host_link_pkg::*;
#(
  parameter int MAX_BITS = ECC_MAX_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                arm,
  input  logic [CNT_W-1:0]    n_m1,
  input  logic                i_valid,
  input  logic                i_x,
  input  logic                i_y,
  output logic                full,
  output logic [MAX_BITS-1:0] res_x,
  output logic [MAX_BITS-1:0] res_y
);

  cap_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [MAX_BITS-1:0] x_q, x_d, y_q, y_d;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    if (arm) begin
      state_d = CAP_WAIT;
      cnt_d   = '0;
      x_d     = '0;
      y_d     = '0;
    end else begin
      case (state_q)
        CAP_WAIT: begin
          if (i_valid) begin
            state_d = CAP_SHIFT;
            cnt_d   = '0;
            x_d     = MAX_BITS'(i_x);
            y_d     = MAX_BITS'(i_y);
          end
        end
        CAP_SHIFT: begin
          x_d   = {x_q[MAX_BITS-2:0], i_x};
          y_d   = {y_q[MAX_BITS-2:0], i_y};
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == n_m1) state_d = CAP_FULL;
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CAP_IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  assign full  = (state_q == CAP_FULL);
  assign res_x = x_q;
  assign res_y = y_q;

endmodule

// File: rtl/ecc_host_link.sv
// Host-side serial link to the ECC wrapper: streams mP and nP requests MSB
// first and captures the two serial result pairs back into parallel words.
module ecc_host_link
  import ecc_host_link_pkg::*;
#(
  parameter int NP_DELAY = 10,
  parameter int MAX_BITS = ECC_MAX_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [1:0]          mode,
  input  logic [MAX_BITS-1:0] a,
  input  logic [MAX_BITS-1:0] b,
  input  logic [MAX_BITS-1:0] prime,
  input  logic [MAX_BITS-1:0] px,
  input  logic [MAX_BITS-1:0] py,
  input  logic [MAX_BITS-1:0] m,
  input  logic [MAX_BITS-1:0] npx,
  input  logic [MAX_BITS-1:0] npy,
  output logic                busy,
  output logic                done,
  output logic [MAX_BITS-1:0] mpx,
  output logic [MAX_BITS-1:0] mpy,
  output logic [MAX_BITS-1:0] mnpx,
  output logic [MAX_BITS-1:0] mnpy,
  output logic                o_m_P_valid,
  output logic                o_nP_valid,
  output logic                o_mode,
  output logic                o_a,
  output logic                o_b,
  output logic                o_prime,
  output logic                o_Px,
  output logic                o_Py,
  output logic                o_m,
  output logic                o_nPx,
  output logic                o_nPy,
  input  logic                i_mP_valid,
  input  logic                i_mnP_valid,
  input  logic                i_mPx,
  input  logic                i_mPy,
  input  logic                i_mnPx,
  input  logic                i_mnPy
);

  localparam logic [CNT_W-1:0] NP_WAIT_LAST = CNT_W'(NP_DELAY - 1);

  tx_state_e                tx_state_q, tx_state_d;
  np_state_e                np_state_q, np_state_d;
  logic [CNT_W-1:0]         tx_cnt_q, tx_cnt_d, np_cnt_q, np_cnt_d, n_m1_q, n_m1_d;
  logic [1:0]               mode_q, mode_d;
  logic                     busy_q, busy_d, done_q, done_d;
  logic [5:0][MAX_BITS-1:0] mp_sr_q, mp_sr_d;
  logic [1:0][MAX_BITS-1:0] np_sr_q, np_sr_d;
  logic                     accept, mp_full, mnp_full;
  logic [CNT_W-1:0]         n_m1_new;
  logic [31:0]              align;

  assign accept   = start & ~busy_q;
  assign n_m1_new = bits_m1(mode_e'(mode));
  // Operands are left-aligned at launch so the serial bit is always the MSB.
  assign align    = 32'(MAX_BITS - 1) - 32'(n_m1_new);

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    np_state_d = np_state_q;
    np_cnt_d   = np_cnt_q;
    mode_d     = mode_q;
    n_m1_d     = n_m1_q;
    mp_sr_d    = mp_sr_q;
    np_sr_d    = np_sr_q;
    done_d     = busy_q & mp_full & mnp_full & ~done_q;
    busy_d     = accept | (busy_q & ~done_q);
    if (accept) begin
      mode_d     = mode;
      n_m1_d     = n_m1_new;
      mp_sr_d    = {m << align, py << align, px << align,
                    prime << align, b << align, a << align};
      np_sr_d    = {npy << align, npx << align};
      tx_state_d = TX_VALID;
      tx_cnt_d   = '0;
      np_state_d = NP_WAIT;
      np_cnt_d   = '0;
    end else begin
      case (tx_state_q)
        TX_VALID: tx_state_d = TX_MODE1;
        TX_MODE1: tx_state_d = TX_MODE0;
        TX_MODE0: tx_state_d = TX_DATA;
        TX_DATA: begin
          for (int i = 0; i < 6; i++) mp_sr_d[i] = mp_sr_q[i] << 1;
          if (tx_cnt_q == n_m1_q) tx_state_d = TX_IDLE;
          else                    tx_cnt_d   = tx_cnt_q + 1'b1;
        end
        default: ;
      endcase
      case (np_state_q)
        NP_WAIT: begin
          if (np_cnt_q == NP_WAIT_LAST) begin
            np_state_d = NP_VALID;
            np_cnt_d   = '0;
          end else begin
            np_cnt_d = np_cnt_q + 1'b1;
          end
        end
        NP_VALID: np_state_d = NP_DATA;
        NP_DATA: begin
          for (int i = 0; i < 2; i++) np_sr_d[i] = np_sr_q[i] << 1;
          if (np_cnt_q == n_m1_q) np_state_d = NP_IDLE;
          else                    np_cnt_d   = np_cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      np_state_q <= NP_IDLE;
      np_cnt_q   <= '0;
      mode_q     <= '0;
      n_m1_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      np_state_q <= np_state_d;
      np_cnt_q   <= np_cnt_d;
      mode_q     <= mode_d;
      n_m1_q     <= n_m1_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // NOTE: operand shift registers carry no reset; every serial output is gated by FSM state.
  always_ff @(posedge clk) begin
    mp_sr_q <= mp_sr_d;
    np_sr_q <= np_sr_d;
  end

  ecc_serial_capture #(.MAX_BITS(MAX_BITS)) u_cap_mp (
    .clk     (clk),
    .rst     (rst),
    .arm     (accept),
    .n_m1    (n_m1_q),
    .i_valid (i_mP_valid),
    .i_x     (i_mPx),
    .i_y     (i_mPy),
    .full    (mp_full),
    .res_x   (mpx),
    .res_y   (mpy)
  );

  ecc_serial_capture #(.MAX_BITS(MAX_BITS)) u_cap_mnp (
    .clk     (clk),
    .rst     (rst),
    .arm     (accept),
    .n_m1    (n_m1_q),
    .i_valid (i_mnP_valid),
    .i_x     (i_mnPx),
    .i_y     (i_mnPy),
    .full    (mnp_full),
    .res_x   (mnpx),
    .res_y   (mnpy)
  );

  assign busy        = busy_q;
  assign done        = done_q;
  assign o_m_P_valid = (tx_state_q == TX_VALID);
  assign o_mode      = ((tx_state_q == TX_MODE1) & mode_q[1]) |
                       ((tx_state_q == TX_MODE0) & mode_q[0]);
  assign o_a         = (tx_state_q == TX_DATA) & mp_sr_q[0][MAX_BITS-1];
  assign o_b         = (tx_state_q == TX_DATA) & mp_sr_q[1][MAX_BITS-1];
  assign o_prime     = (tx_state_q == TX_DATA) & mp_sr_q[2][MAX_BITS-1];
  assign o_Px        = (tx_state_q == TX_DATA) & mp_sr_q[3][MAX_BITS-1];
  assign o_Py        = (tx_state_q == TX_DATA) & mp_sr_q[4][MAX_BITS-1];
  assign o_m         = (tx_state_q == TX_DATA) & mp_sr_q[5][MAX_BITS-1];
  assign o_nP_valid  = (np_state_q == NP_VALID);
  assign o_nPx       = (np_state_q == NP_DATA) & np_sr_q[0][MAX_BITS-1];
  assign o_nPy       = (np_state_q == NP_DATA) & np_sr_q[1][MAX_BITS-1];

endmodule

// File: tb/tb_ecc_host_link.sv
// Randomized bench for ecc_host_link: a cycle-timed model built from the link
// timing rules predicts every serial/control output and the captured results.
module tb_ecc_host_link;

  localparam int NP_DELAY = 10;
  localparam int W        = 256;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [1:0]   mode;
  logic [W-1:0] a, b, prime, px, py, m, npx, npy;
  logic         busy, done;
  logic [W-1:0] mpx, mpy, mnpx, mnpy;
  logic         o_m_P_valid, o_nP_valid, o_mode;
  logic         o_a, o_b, o_prime, o_Px, o_Py, o_m, o_nPx, o_nPy;
  logic         i_mP_valid, i_mnP_valid, i_mPx, i_mPy, i_mnPx, i_mnPy;

  int total = 0;
  int bad   = 0;

  // current transaction: operands a,b,prime,px,py,m,npx,npy and results mpx,mpy,mnpx,mnpy
  logic [1:0]         t_md;
  logic [7:0][W-1:0]  t_op;
  logic [3:0][W-1:0]  t_res;
  int                 t_tm, t_tn, t_extra;

  always #5 clk = ~clk;

  ecc_host_link #(.NP_DELAY(NP_DELAY), .MAX_BITS(W)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .a(a), .b(b), .prime(prime), .px(px), .py(py), .m(m), .npx(npx), .npy(npy),
    .busy(busy), .done(done), .mpx(mpx), .mpy(mpy), .mnpx(mnpx), .mnpy(mnpy),
    .o_m_P_valid(o_m_P_valid), .o_nP_valid(o_nP_valid), .o_mode(o_mode),
    .o_a(o_a), .o_b(o_b), .o_prime(o_prime), .o_Px(o_Px), .o_Py(o_Py), .o_m(o_m),
    .o_nPx(o_nPx), .o_nPy(o_nPy),
    .i_mP_valid(i_mP_valid), .i_mnP_valid(i_mnP_valid),
    .i_mPx(i_mPx), .i_mPy(i_mPy), .i_mnPx(i_mnPx), .i_mnPy(i_mnPy)
  );

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_wide();
    logic [W-1:0] v;
    for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [12:0] obs();
    return {o_m_P_valid, o_mode, o_a, o_b, o_prime, o_Px, o_Py, o_m,
            o_nP_valid, o_nPx, o_nPy, busy, done};
  endfunction

  task automatic scramble_inputs();
    mode = 2'($urandom);
    a = rand_wide(); b = rand_wide(); prime = rand_wide(); px = rand_wide();
    py = rand_wide(); m = rand_wide(); npx = rand_wide(); npy = rand_wide();
  endtask

  // Serial bits a result source drives k cycles after its valid marker.
  task automatic chan_bits(input int k, input int n, input logic [W-1:0] rx, input logic [W-1:0] ry,
                           output logic v, output logic x, output logic y);
    if (k < 0) begin
      v = 1'b0; x = 1'($urandom); y = 1'($urandom);
    end else if (k == 0) begin
      v = 1'b1; x = rx[n-1]; y = ry[n-1];
    end else if (k < n) begin
      v = 1'($urandom); x = rx[n-1-k]; y = ry[n-1-k];
    end else begin
      v = 1'($urandom); x = 1'($urandom); y = 1'($urandom);
    end
  endtask

  task automatic new_txn(input logic [1:0] md, input int tm, input int tn, input int extra);
    t_md = md; t_tm = tm; t_tn = tn; t_extra = extra;
    for (int i = 0; i < 8; i++) t_op[i] = rand_wide();
    for (int i = 0; i < 4; i++) t_res[i] = rand_wide();
  endtask

  // Called at a negedge; start is sampled at the next rising edge (cycle 0).
  task automatic run_txn();
    int           n, done_c, last, kd, kn;
    logic [W-1:0] all1, mask;
    logic [12:0]  e;
    n      = 32 << t_md;
    done_c = ((t_tm > t_tn) ? t_tm : t_tn) + n + 1;
    last   = (((NP_DELAY + 1 + n) > done_c) ? (NP_DELAY + 1 + n) : done_c) + 2;
    all1   = '1;
    mask   = all1 >> (W - n);
    mode = t_md; a = t_op[0]; b = t_op[1]; prime = t_op[2]; px = t_op[3];
    py = t_op[4]; m = t_op[5]; npx = t_op[6]; npy = t_op[7];
    start = 1'b1;
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      start = (c == t_extra);
      if (c == 1 || c == t_extra) scramble_inputs();
      e = '0;
      e[12] = (c == 1);
      e[11] = (c == 2) ? t_md[1] : ((c == 3) ? t_md[0] : 1'b0);
      kd = c - 4;
      if (kd >= 0 && kd < n)
        for (int j = 0; j < 6; j++) e[10-j] = t_op[j][n-1-kd];
      e[4] = (c == NP_DELAY + 1);
      kn = c - (NP_DELAY + 2);
      if (kn >= 0 && kn < n) begin
        e[3] = t_op[6][n-1-kn];
        e[2] = t_op[7][n-1-kn];
      end
      e[1] = (c <= done_c);
      e[0] = (c == done_c);
      check($sformatf("ctl_m%0d_c%0d", t_md, c), W'(obs()), W'(e));
      if (c == 1) begin
        check("clr_mpx", mpx, '0);
        check("clr_mnpy", mnpy, '0);
      end
      chan_bits(c - t_tm, n, t_res[0], t_res[1], i_mP_valid, i_mPx, i_mPy);
      chan_bits(c - t_tn, n, t_res[2], t_res[3], i_mnP_valid, i_mnPx, i_mnPy);
    end
    {i_mP_valid, i_mPx, i_mPy, i_mnP_valid, i_mnPx, i_mnPy} = '0;
    check($sformatf("mpx_m%0d", t_md), mpx, t_res[0] & mask);
    check($sformatf("mpy_m%0d", t_md), mpy, t_res[1] & mask);
    check($sformatf("mnpx_m%0d", t_md), mnpx, t_res[2] & mask);
    check($sformatf("mnpy_m%0d", t_md), mnpy, t_res[3] & mask);
  endtask

  // Launch a 64-bit run, feed part of the mP result, then reset in DATA.
  task automatic reset_mid();
    logic [W-1:0] r;
    new_txn(2'b01, 1, 200, 0);
    r = t_res[0];
    r[63] = 1'b1;
    mode = t_md; a = t_op[0]; b = t_op[1]; prime = t_op[2]; px = t_op[3];
    py = t_op[4]; m = t_op[5]; npx = t_op[6]; npy = t_op[7];
    start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = 1'b0;
      chan_bits(c - 1, 64, r, r, i_mP_valid, i_mPx, i_mPy);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    {i_mP_valid, i_mPx, i_mPy} = '0;
    check("rst_mid_ctl", W'(obs()), '0);
    check("rst_mid_mpx", mpx, '0);
    check("rst_mid_mpy", mpy, '0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = '0;
    {a, b, prime, px, py, m, npx, npy} = '0;
    {i_mP_valid, i_mPx, i_mPy, i_mnP_valid, i_mnPx, i_mnPy} = '0;
    repeat (3) @(negedge clk);
    check("reset_ctl", W'(obs()), '0);
    check("reset_mpx", mpx, '0);
    check("reset_mnpx", mnpx, '0);
    rst = 1'b0;

    // result markers before any start must not be captured
    {i_mP_valid, i_mPx, i_mPy, i_mnP_valid, i_mnPx, i_mnPy} = '1;
    @(negedge clk);
    {i_mP_valid, i_mPx, i_mPy, i_mnP_valid, i_mnPx, i_mnPy} = '0;
    repeat (4) @(negedge clk);
    check("unarmed_mpx", mpx, '0);
    check("unarmed_mnpy", mnpy, '0);
    check("unarmed_ctl", W'(obs()), '0);

    // 32-bit, known operand and results, mnP 5 cycles after mP
    new_txn(2'b00, 40, 45, 0);
    t_op[0]  = W'(32'hA5A5_0001);
    t_res[0] = W'(32'hDEAD_BEEF);
    t_res[2] = W'(32'h1234_5678);
    run_txn();

    // mnP before mP, with an ignored restart while busy
    new_txn(2'b01, 50, 30, 5);
    run_txn();

    // both markers in the same cycle
    new_txn(2'b10, 20, 20, 0);
    run_txn();

    // full width, MSB and LSB set everywhere
    new_txn(2'b11, 263, 261, 6);
    for (int i = 0; i < 8; i++) begin t_op[i][W-1] = 1'b1; t_op[i][0] = 1'b1; end
    for (int i = 0; i < 4; i++) begin t_res[i][W-1] = 1'b1; t_res[i][0] = 1'b1; end
    run_txn();

    // results arriving while the request is still streaming
    new_txn(2'b00, 2, 2, 0);
    run_txn();

    for (int i = 0; i < 4; i++) begin
      new_txn(2'($urandom_range(0, 3)), $urandom_range(1, 60), $urandom_range(1, 60),
              $urandom_range(2, 8));
      run_txn();
    end

    reset_mid();
    new_txn(2'b00, 10, 12, 0);
    run_txn();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
